// File: rtl/vga_timing_gen.sv
// VGA raster timing: sweeps pixelX/pixelY, delays sync/blank to match the RGB pipeline, blanks RGB to the DAC.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_mode input that replaces rgb_in with eight colour bars.
module vga_timing_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int PIPE_DELAY = 1
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        clk_en,
   input  logic [11:0] rgb_in,
`ifdef VGA_TEST_PATTERN_EN
   input  logic        test_mode,
`endif
   output logic [10:0] pixelX,
   output logic [10:0] pixelY,
   output logic        startOfFrame,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blankN,
   output logic [11:0] vga_RGB
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   logic [10:0]           hcnt_q, hcnt_d;
   logic [10:0]           vcnt_q, vcnt_d;
   logic                  sof_q, sof_d;
   logic                  act_raw, hs_raw, vs_raw;
   logic [PIPE_DELAY-1:0] act_q, act_d;
   logic [PIPE_DELAY-1:0] hs_q, hs_d;
   logic [PIPE_DELAY-1:0] vs_q, vs_d;
   logic [11:0]           rgb_q, rgb_d;
   logic [11:0]           pix_colour;

   // Frame wrap is the only source of startOfFrame, so a reset restart never pulses it.
   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      sof_d  = 1'b0;
      if (clk_en) begin
         if (hcnt_q == 11'(H_TOTAL - 1)) begin
            hcnt_d = '0;
            if (vcnt_q == 11'(V_TOTAL - 1)) begin
               vcnt_d = '0;
               sof_d  = 1'b1;
            end else begin
               vcnt_d = vcnt_q + 11'd1;
            end
         end else begin
            hcnt_d = hcnt_q + 11'd1;
         end
      end
   end

   always_comb begin
      act_raw = (hcnt_q < 11'(H_ACTIVE)) && (vcnt_q < 11'(V_ACTIVE));
      hs_raw  = !((hcnt_q >= 11'(HS_START)) && (hcnt_q < 11'(HS_END)));
      vs_raw  = !((vcnt_q >= 11'(VS_START)) && (vcnt_q < 11'(VS_END)));
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;
   localparam logic [11:0] BAR_RGB [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                           12'hF0F, 12'hF00, 12'h00F, 12'h000};

   // Horizontal position only travels down the pipe when the bars need it.
   logic [PIPE_DELAY-1:0][10:0] x_q, x_d;
   logic [2:0]                  bar_idx;

   always_comb begin
      x_d = x_q;
      if (clk_en) begin
         x_d[0] = hcnt_q;
         for (int i = 1; i < PIPE_DELAY; i++) x_d[i] = x_q[i-1];
      end
      bar_idx = '0;
      for (int i = 1; i < 8; i++) begin
         if (x_d[PIPE_DELAY-1] >= 11'(i * BAR_W)) bar_idx = 3'(i);
      end
      pix_colour = test_mode ? BAR_RGB[bar_idx] : rgb_in;
   end
`else
   always_comb pix_colour = rgb_in;
`endif

   // The RGB register loads from the value entering the last stage so colour and blank land together.
   always_comb begin
      act_d = act_q;
      hs_d  = hs_q;
      vs_d  = vs_q;
      rgb_d = rgb_q;
      if (clk_en) begin
         act_d[0] = act_raw;
         hs_d[0]  = hs_raw;
         vs_d[0]  = vs_raw;
         for (int i = 1; i < PIPE_DELAY; i++) begin
            act_d[i] = act_q[i-1];
            hs_d[i]  = hs_q[i-1];
            vs_d[i]  = vs_q[i-1];
         end
         rgb_d = act_d[PIPE_DELAY-1] ? pix_colour : 12'h000;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
         sof_q  <= 1'b0;
         act_q  <= '0;
         hs_q   <= '1;
         vs_q   <= '1;
         rgb_q  <= '0;
`ifdef VGA_TEST_PATTERN_EN
         x_q    <= '0;
`endif
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
         sof_q  <= sof_d;
         act_q  <= act_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         rgb_q  <= rgb_d;
`ifdef VGA_TEST_PATTERN_EN
         x_q    <= x_d;
`endif
      end
   end

   assign pixelX       = hcnt_q;
   assign pixelY       = vcnt_q;
   assign startOfFrame = sof_q;
   assign vga_hs       = hs_q[PIPE_DELAY-1];
   assign vga_vs       = vs_q[PIPE_DELAY-1];
   assign vga_blankN   = act_q[PIPE_DELAY-1];
   assign vga_RGB      = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster; a reference model feeds an expected queue per cycle.
`timescale 1ns/1ps
module tb_vga_timing_gen;
   localparam int H_ACTIVE = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
   localparam int V_ACTIVE = 12, V_FP = 2, V_SYNC = 2, V_BP = 3;
   localparam int P        = 2;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int N_FRAME  = H_TOTAL * V_TOTAL;
   localparam int EXP_W    = 38;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        clk_en = 1'b0;
   logic [11:0] rgb_in = '0;
`ifdef VGA_TEST_PATTERN_EN
   logic        test_mode = 1'b0;
   logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                             12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif
   logic [10:0] pixelX, pixelY;
   logic        startOfFrame, vga_hs, vga_vs, vga_blankN;
   logic [11:0] vga_RGB;

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .PIPE_DELAY(P)
   ) dut (
      .clk(clk), .resetN(resetN), .clk_en(clk_en), .rgb_in(rgb_in),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode(test_mode),
`endif
      .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blankN(vga_blankN), .vga_RGB(vga_RGB)
   );

   // clock/reset block
   always #5 clk = ~clk;

   // scoreboard state: {x, y, sof, hs, vs, blankN, rgb}
   logic [EXP_W-1:0] exp_q[$];
   logic [13:0]      hist_q[$];   // {act, hs, vs, x}
   logic [13:0]      last_out;
   logic [11:0]      last_rgb;
   int mx, my;
   int total = 0;
   int bad   = 0;

   bit stats_on = 1'b0;
   int n_st, hs_low, bn_high, vs_low, sof_cnt, sof_at, sof_org, x_pk, y_pk;
   int x_sync, first_hs, y_sync, first_vs, first_c60;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] raw_of(input int x, input int y);
      logic act, hs, vs;
      act = (x < H_ACTIVE) && (y < V_ACTIVE);
      hs  = !(x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC);
      vs  = !(y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC);
      return {act, hs, vs, 11'(x)};
   endfunction

   task automatic model_reset();
      mx = 0;
      my = 0;
      hist_q.delete();
      repeat (P - 1) hist_q.push_back({1'b0, 1'b1, 1'b1, 11'd0});
      last_out = {1'b0, 1'b1, 1'b1, 11'd0};
      last_rgb = 12'h000;
   endtask

   task automatic clear_stats();
      n_st = 0; hs_low = 0; bn_high = 0; vs_low = 0; sof_cnt = 0; sof_at = -1;
      sof_org = 0; x_pk = 0; y_pk = 0; x_sync = -1; first_hs = -1;
      y_sync = -1; first_vs = -1; first_c60 = -1;
   endtask

   task automatic check_reset_values(input string pfx);
      chk({pfx, "_pixelX"}, 32'(pixelX), 0);
      chk({pfx, "_pixelY"}, 32'(pixelY), 0);
      chk({pfx, "_sof"}, 32'(startOfFrame), 0);
      chk({pfx, "_hs"}, 32'(vga_hs), 1);
      chk({pfx, "_vs"}, 32'(vga_vs), 1);
      chk({pfx, "_blankN"}, 32'(vga_blankN), 0);
      chk({pfx, "_rgb"}, 32'(vga_RGB), 0);
   endtask

   // driver task: drive one clock, push the model's prediction, pop and compare after the edge
   task automatic step(input logic en, input logic [11:0] rgb);
      logic [13:0]      o;
      logic             sof;
      logic [11:0]      col;
      logic [EXP_W-1:0] e;
      clk_en = en;
      rgb_in = rgb;
      sof    = 1'b0;
      if (en) begin
         hist_q.push_back(raw_of(mx, my));
         o   = hist_q.pop_front();
         sof = (mx == H_TOTAL - 1) && (my == V_TOTAL - 1);
         if (mx == H_TOTAL - 1) begin
            mx = 0;
            my = (my == V_TOTAL - 1) ? 0 : my + 1;
         end else begin
            mx++;
         end
         col = o[13] ? rgb : 12'h000;
`ifdef VGA_TEST_PATTERN_EN
         if (o[13] && test_mode) col = bars[int'(o[10:0]) / (H_ACTIVE / 8)];
`endif
         last_out = o;
         last_rgb = col;
      end
      exp_q.push_back({11'(mx), 11'(my), sof, last_out[12], last_out[11], last_out[13], last_rgb});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("pixelX", 32'(pixelX), 32'(e[37:27]));
      chk("pixelY", 32'(pixelY), 32'(e[26:16]));
      chk("startOfFrame", 32'(startOfFrame), 32'(e[15]));
      chk("vga_hs", 32'(vga_hs), 32'(e[14]));
      chk("vga_vs", 32'(vga_vs), 32'(e[13]));
      chk("vga_blankN", 32'(vga_blankN), 32'(e[12]));
      chk("vga_RGB", 32'(vga_RGB), 32'(e[11:0]));
      if (stats_on) begin
         if (startOfFrame) begin
            sof_cnt++;
            sof_at  = n_st + 1;
            sof_org = (pixelX == 0 && pixelY == 0) ? 1 : 0;
         end
         if (en) begin
            n_st++;
            if (!vga_hs) begin hs_low++; if (first_hs < 0) first_hs = n_st; end
            if (!vga_vs) begin vs_low++; if (first_vs < 0) first_vs = n_st; end
            if (vga_blankN) bn_high++;
            if (int'(pixelX) > x_pk) x_pk = int'(pixelX);
            if (int'(pixelY) > y_pk) y_pk = int'(pixelY);
            if (pixelX == 11'(H_ACTIVE + H_FP) && x_sync < 0) x_sync = n_st;
            if (pixelY == 11'(V_ACTIVE + V_FP) && pixelX == 0 && y_sync < 0) y_sync = n_st;
            if (vga_RGB == 12'hC60 && first_c60 < 0) first_c60 = n_st;
         end
      end
   endtask

   initial begin
      bit reached;
      clear_stats();
      model_reset();

      // reset state
      resetN = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("rst");

      // one full frame, constant colour, one pixel per clock
      @(negedge clk);
      resetN = 1'b1;
      model_reset();
      clear_stats();
      stats_on = 1'b1;
      repeat (N_FRAME) step(1'b1, 12'hC60);
      stats_on = 1'b0;
      chk("sof_count", 32'(sof_cnt), 1);
      chk("sof_position", 32'(sof_at), 32'(N_FRAME));
      chk("sof_at_origin", 32'(sof_org), 1);
      chk("pixelX_peak", 32'(x_pk), 32'(H_TOTAL - 1));
      chk("pixelY_peak", 32'(y_pk), 32'(V_TOTAL - 1));
      chk("hs_low_strobes", 32'(hs_low), 32'(H_SYNC * V_TOTAL));
      chk("blankN_high_strobes", 32'(bn_high), 32'(H_ACTIVE * V_ACTIVE));
      chk("vs_low_strobes", 32'(vs_low), 32'(V_SYNC * H_TOTAL));
      chk("hs_lag", 32'(first_hs - x_sync), 32'(P));
      chk("vs_lag", 32'(first_vs - y_sync), 32'(P));
      chk("first_c60", 32'(first_c60), 32'(P));

      // strobe every other clock until mid-frame, then reset asynchronously
      reached = 1'b0;
      for (int i = 0; i < 4 * N_FRAME && !reached; i++) begin
         step(1'((i % 2) == 0), 12'($urandom_range(0, 4095)));
         if (pixelX == 11'd30 && pixelY == 11'd5) reached = 1'b1;
      end
      chk("reached_mid_frame", 32'(reached), 1);
      #3;
      resetN = 1'b0;
      #1;
      check_reset_values("async_rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetN = 1'b1;
      model_reset();
      clear_stats();
      stats_on = 1'b1;
      repeat (20) step(1'b1, 12'($urandom_range(0, 4095)));
      stats_on = 1'b0;
      chk("no_sof_after_reset", 32'(sof_cnt), 0);

      // random strobe pattern and colours across more than a frame, including vertical blanking
      repeat (2 * N_FRAME) step(1'($urandom_range(0, 3) != 0), 12'($urandom_range(0, 4095)));

`ifdef VGA_TEST_PATTERN_EN
      test_mode = 1'b1;
      repeat (N_FRAME) step(1'b1, 12'($urandom_range(0, 4095)));
      test_mode = 1'b0;
      repeat (4) step(1'b1, 12'hC60);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      bad++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
